// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares one single-port synchronous video RAM between the display scan-out
// fetch path and a host (CPU / game logic) port. The display has fixed
// priority so scan-out timing never slips; the host uses a level req / pulse
// gnt handshake and is served in free cycles.
//
// One owner decision is made per cycle from the inputs of cycle N and becomes
// the RAM access of cycle N+1. RAM read data returns one cycle after the
// address cycle, so read data valid pulses appear in N+2 for the display and
// in the cycle after host_gnt for the host.
//
// Optional feature (compile-time macro ARB_STARVE_GUARD_EN):
//   When defined, a host that has waited STARVE_LIMIT cycles is given the next
//   slot even against a display request; that display request is dropped and
//   disp_miss pulses. When undefined, display priority is absolute and
//   disp_miss is constant 0.
//
// Parameters:
//   AW           VRAM address width
//   DW           VRAM data width
//   STARVE_LIMIT host wait cycles before host_starve (2..255)
//
// Ports:
//   clk, reset                  clock (posedge) / async active-low reset
//   disp_req, disp_addr         display fetch request pulse and address
//   disp_rvalid, disp_rdata     display read return
//   disp_miss                   display request dropped by the starve guard
//   host_req/we/addr/wdata      host request level and access attributes
//   host_gnt                    host access performed this cycle
//   host_rvalid, host_rdata     host read return
//   host_starve                 sticky: host waited >= STARVE_LIMIT cycles
//   ram_addr/we/wdata           registered RAM command
//   ram_rdata                   RAM read data (one cycle after address)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vram_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_miss,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          host_starve,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic [7:0] wait_q, wait_d;
  logic       force_host;
  logic       miss_d;

  // The owner register doubles as the read tag of the access now on the RAM:
  // one stage is enough because read data returns exactly one cycle later.
  assign host_gnt   = (owner_q == OWN_HOST);
  assign disp_rdata = ram_rdata;
  assign host_rdata = ram_rdata;

  // ---------------------------------------------------------------------------
  // Next-owner decision and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    owner_d    = OWN_IDLE;
    wait_d     = wait_q;
    force_host = 1'b0;
    miss_d     = 1'b0;

`ifdef ARB_STARVE_GUARD_EN
    force_host = host_req && !host_gnt && (wait_q == 8'(STARVE_LIMIT));
`endif

    if (force_host) begin
      owner_d = OWN_HOST;
      miss_d  = disp_req;
    end else if (disp_req) begin
      owner_d = OWN_DISP;
    end else if (host_req && !host_gnt) begin
      // host_req is ignored during the gnt cycle: the requester has not yet
      // seen the grant and may still be holding the old request.
      owner_d = OWN_HOST;
    end

    if (host_gnt) begin
      wait_d = 8'd0;
    end else if (host_req && (owner_d != OWN_HOST) && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner state and wait counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_IDLE;
      wait_q  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM command, return strobes and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_miss   <= 1'b0;
      host_starve <= 1'b0;
    end else begin
      case (owner_d)
        OWN_DISP: begin
          ram_addr <= disp_addr;
          ram_we   <= 1'b0;
        end
        OWN_HOST: begin
          ram_addr  <= host_addr;
          ram_we    <= host_we;
          ram_wdata <= host_wdata;
        end
        default: begin
          // Idle slot: address and write data hold, no write.
          ram_we <= 1'b0;
        end
      endcase

      // Return strobes follow the access currently on the RAM by one cycle.
      disp_rvalid <= (owner_q == OWN_DISP);
      host_rvalid <= (owner_q == OWN_HOST) && !ram_we;
      disp_miss   <= miss_d;

      if (wait_d == 8'(STARVE_LIMIT)) begin
        host_starve <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
`timescale 1ns/1ps

module tb_vram_port_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int LIMIT = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          disp_miss;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          host_starve;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .disp_miss   (disp_miss),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_starve (host_starve),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Behavioural single-port synchronous RAM (read-first, 1-cycle read latency)
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37 + 11) ^ (a >> 2));
  endfunction

  logic [DW-1:0] ram [DEPTH];
  bit            ram_written [DEPTH];

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr]         <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
    ram_rdata <= ram_written[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
  end

  // ---------------------------------------------------------------------------
  // Reference model state: expected memory image and expected outputs
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_tests = 0;
  int            n_fail  = 0;

  bit            m_gnt;     // host_gnt expected in the current cycle
  int            m_wait;    // host wait cycles
  bit            m_starve;
  bit            m_miss;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  bit            pv_d, pv_h; // return expected in the current cycle
  logic [DW-1:0] pv_data;
  bit            nv_d, nv_h; // return expected in the next cycle
  logic [DW-1:0] nv_data;
  bit            h_pending;

  int cnt_gnt, cnt_drv, cnt_hrv, cnt_miss, gnt_b2b;
  bit prev_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_gnt = 0; m_wait = 0; m_starve = 0; m_miss = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    pv_d = 0; pv_h = 0; pv_data = '0;
    nv_d = 0; nv_h = 0; nv_data = '0;
    h_pending = 0; prev_gnt = 0;
    host_req = 1'b0; disp_req = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_gnt = 0; cnt_drv = 0; cnt_hrv = 0; cnt_miss = 0; gnt_b2b = 0;
  endtask

  // Assert reset asynchronously, check outputs at once, release later on a
  // falling edge.
  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    #1;
    check("rst_ram_addr",    32'(ram_addr),    0);
    check("rst_ram_we",      32'(ram_we),      0);
    check("rst_ram_wdata",   32'(ram_wdata),   0);
    check("rst_host_gnt",    32'(host_gnt),    0);
    check("rst_disp_rvalid", 32'(disp_rvalid), 0);
    check("rst_host_rvalid", 32'(host_rvalid), 0);
    check("rst_disp_miss",   32'(disp_miss),   0);
    check("rst_host_starve", 32'(host_starve), 0);
    clear_model();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    h_pending  = 1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  // One clock cycle: drive inputs, predict from the arbitration rules, advance,
  // then compare every output against the prediction.
  task automatic tick(input bit dreq, input logic [AW-1:0] daddr);
    bit force_h;
    int dec; // 0 idle, 1 display, 2 host
    disp_req  = dreq;
    disp_addr = daddr;
    host_req  = h_pending;

    force_h = 0;
`ifdef ARB_STARVE_GUARD_EN
    force_h = h_pending && !m_gnt && (m_wait == LIMIT);
`endif
    if (force_h)                 dec = 2;
    else if (dreq)               dec = 1;
    else if (h_pending && !m_gnt) dec = 2;
    else                         dec = 0;

    if (m_gnt)                        m_wait = 0;
    else if (h_pending && dec != 2)   m_wait = (m_wait < 255) ? m_wait + 1 : 255;
    if (m_wait >= LIMIT) m_starve = 1;

    m_miss = force_h && dreq;
    nv_d   = (dec == 1);
    nv_h   = (dec == 2) && !host_we;
    if (dec == 1) begin
      m_addr  = daddr;
      m_we    = 1'b0;
      nv_data = ref_mem[daddr];
    end else if (dec == 2) begin
      m_addr  = host_addr;
      m_we    = host_we;
      m_wdata = host_wdata;
      if (host_we) ref_mem[host_addr] = host_wdata;
      else         nv_data = ref_mem[host_addr];
    end else begin
      m_we = 1'b0;
    end
    m_gnt = (dec == 2);

    @(posedge clk);
    #1;
    check("ram_addr",    32'(ram_addr),    32'(m_addr));
    check("ram_we",      32'(ram_we),      32'(m_we));
    check("ram_wdata",   32'(ram_wdata),   32'(m_wdata));
    check("host_gnt",    32'(host_gnt),    32'(m_gnt));
    check("disp_miss",   32'(disp_miss),   32'(m_miss));
    check("host_starve", 32'(host_starve), 32'(m_starve));
    check("disp_rvalid", 32'(disp_rvalid), 32'(pv_d));
    check("host_rvalid", 32'(host_rvalid), 32'(pv_h));
    if (pv_d) check("disp_rdata", 32'(disp_rdata), 32'(pv_data));
    if (pv_h) check("host_rdata", 32'(host_rdata), 32'(pv_data));

    if (host_gnt) cnt_gnt++;
    if (host_gnt && prev_gnt) gnt_b2b++;
    prev_gnt = host_gnt;
    if (disp_rvalid) cnt_drv++;
    if (host_rvalid) cnt_hrv++;
    if (disp_miss)   cnt_miss++;

    if (m_gnt) h_pending = 0;
    pv_d = nv_d; pv_h = nv_h; pv_data = nv_data;
  endtask

  // Idle display until the pending host op is granted (bounded).
  task automatic run_to_gnt(input string tag);
    int k;
    k = 0;
    while (h_pending && k < 50) begin
      tick(1'b0, '0);
      k++;
    end
    check({tag, "_gnt_bound"}, 32'(h_pending), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    clear_counts();
    #2;

    // 1) Reset held for 7 cycles, then a first display read of 0x010.
    apply_reset(7);
    tick(1'b1, 10'h010);
    check("first_disp_addr", 32'(ram_addr), 32'h010);
    tick(1'b0, '0);
    check("first_disp_rvalid", 32'(disp_rvalid), 1);
    check("first_disp_rdata",  32'(disp_rdata),  32'(init_val(16)));

    // 2) Host write 0xA5 to 0x3FF, then host read of 0x3FF.
    clear_counts();
    host_op(1'b1, 10'h3FF, 8'hA5);
    run_to_gnt("hwr");
    check("hwr_we",    32'(ram_we),    1);
    check("hwr_wdata", 32'(ram_wdata), 32'hA5);
    host_op(1'b0, 10'h3FF, 8'h00);
    run_to_gnt("hrd");
    tick(1'b0, '0);
    check("hrd_rvalid", 32'(host_rvalid), 1);
    check("hrd_rdata",  32'(host_rdata),  32'hA5);
    check("hwr_hrd_gnt_count", 32'(cnt_gnt), 2);

    // 3) Display and host rise together: display first, host one cycle later.
    host_op(1'b0, 10'h2A0, 8'h00);
    tick(1'b1, 10'h055);
    check("sim_disp_first", 32'(ram_addr), 32'h055);
    check("sim_no_gnt",     32'(host_gnt), 0);
    tick(1'b0, '0);
    check("sim_host_gnt",   32'(host_gnt), 1);
    tick(1'b0, '0);

    // 4) 40 cycles of continuous display requests against a waiting host.
    apply_reset(2);
    clear_counts();
    host_op(1'b1, 10'h155, 8'h3C);
    for (int i = 0; i < 40; i++) tick(1'b1, AW'($urandom_range(0, DEPTH - 1)));
    check("block_starve", 32'(host_starve), 1);
`ifdef ARB_STARVE_GUARD_EN
    check("block_gnt_count",  32'(cnt_gnt),  1);
    check("block_miss_count", 32'(cnt_miss), 1);
`else
    check("block_gnt_count",  32'(cnt_gnt),  0);
    check("block_miss_count", 32'(cnt_miss), 0);
`endif
    tick(1'b0, '0);
    tick(1'b0, '0);
`ifdef ARB_STARVE_GUARD_EN
    check("block_rvalid_count", 32'(cnt_drv), 39);
`else
    check("block_rvalid_count", 32'(cnt_drv), 40);
`endif
    run_to_gnt("block_drain");

    // 5) Reset asserted right after a host read grant: the read never returns.
    host_op(1'b0, 10'h0F0, 8'h00);
    run_to_gnt("mid");
    @(negedge clk);
    apply_reset(2);
    clear_counts();
    for (int i = 0; i < 4; i++) tick(1'b0, '0);
    check("mid_no_host_rvalid", 32'(cnt_hrv), 0);

    // 6) Display every other cycle interleaved with a host read stream.
    clear_counts();
    for (int i = 0; i < 60; i++) begin
      if (!h_pending) host_op(1'b0, AW'($urandom_range(0, 31)), 8'h00);
      tick(i % 2 == 0, AW'($urandom_range(0, 31)));
    end
    run_to_gnt("ilv");
    tick(1'b0, '0);
    check("ilv_no_b2b_gnt", 32'(gnt_b2b), 0);

    // 7) Random traffic: moderate then heavy display load.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 800; i++) begin
        if (!h_pending && $urandom_range(0, 1) == 1)
          host_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        tick($urandom_range(0, 99) < (phase == 0 ? 40 : 95), AW'($urandom_range(0, 15)));
      end
      run_to_gnt("rand");
      tick(1'b0, '0);
      tick(1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the display scan-out path (tile/pixel fetch feeding hsync/vsync/rgb generation) and a host port (CPU or keys-driven game logic writing the frame).
- The display has fixed priority so scan-out timing never slips.
- The host uses a req/gnt handshake and is served in free slots and during blanking.
- Sits between the video sync/scan-out logic and the VRAM inside each game wrapper.

Parameters:
- AW, 10, VRAM address width.
- DW, 8, VRAM data width.
- STARVE_LIMIT, 16, consecutive host wait cycles before host_starve is set (and before a forced slot, when the optional feature is compiled in); legal range 2..255.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- disp_req  in  1  display fetch request; single-cycle pulse, at most one per cycle.
- disp_addr  in  AW  display fetch address, valid with disp_req.
- disp_rvalid  out  1  display read data valid pulse.
- disp_rdata  out  DW  display read data (combinational from ram_rdata).
- disp_miss  out  1  pulse: display request dropped (optional feature only, else tied 0).
- host_req  in  1  host request level; held until host_gnt.
- host_we  in  1  host write (1) / read (0); stable while host_req is high.
- host_addr  in  AW  host address; stable while host_req is high.
- host_wdata  in  DW  host write data; stable while host_req is high.
- host_gnt  out  1  one-cycle pulse: host access performed this cycle.
- host_rvalid  out  1  host read data valid pulse.
- host_rdata  out  DW  host read data (combinational from ram_rdata).
- host_starve  out  1  sticky flag: host waited >= STARVE_LIMIT cycles.
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DW  registered RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after the address cycle.

Behaviour:
- Reset (reset=0, async):
  - Owner state = IDLE; wait counter = 0; read-tag pipeline cleared.
  - All outputs 0: ram_addr, ram_we, ram_wdata, host_gnt, disp_rvalid, host_rvalid, disp_miss, host_starve.
  - Accesses in flight when reset asserts are dropped; no rvalid is produced after reset releases.
- Owner FSM (registered, one decision per cycle, sampled in cycle N, effective in N+1):
  - IDLE: no RAM access in N+1; ram_we=0 and ram_addr holds its last value.
  - DISP: ram_addr=disp_addr, ram_we=0; read tag = DISP.
  - HOST: ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata; host_gnt=1 in N+1; read tag = HOST if host_we=0.
- Arbitration rule for cycle N:
  - disp_req=1 -> DISP.
  - else host_req=1 and host_gnt=0 -> HOST.
  - else IDLE.
  - host_req is ignored in any cycle where host_gnt=1, so a host may issue back-to-back requests at best every 2 cycles.
- Latency:
  - Display read: request in N, address on RAM in N+1, disp_rvalid=1 in N+2 with disp_rdata=ram_rdata.
  - Host read: host_rvalid=1 in the cycle after host_gnt.
  - Host write: commits in the host_gnt cycle; no rvalid is produced.
- Simultaneous disp_req and host_req: display wins and host keeps waiting. Continuous disp_req blocks the host indefinitely (without the feature).
- Wait counter (8 bits):
  - Increments each cycle host_req=1 and host_gnt=0 and the host is not chosen.
  - Clears on host_gnt.
  - Saturates at 255.
  - When it reaches STARVE_LIMIT, host_starve is set and stays set until reset.
- The read-tag pipeline is one stage deep. Pipelined display reads every cycle return every cycle, in order.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - When the wait counter equals STARVE_LIMIT, the next decision is HOST even if disp_req=1.
  - That disp_req is dropped; disp_miss pulses in N+1 and no disp_rvalid is produced for it.
  - Counter clears on the resulting host_gnt.
- Without the macro: display priority is absolute and disp_miss is constant 0.

Test Plan:
- Reset held low, then released at cycle 7 -> all outputs 0; first disp_req (addr 0x010) -> ram_addr=0x010 at +1, disp_rvalid=1 at +2 with RAM content of 0x010.
- Host write 0xA5 to 0x3FF, then host read of 0x3FF -> host_gnt pulses once per request; ram_we=1 with ram_wdata=0xA5 in the first gnt cycle; host_rvalid one cycle after the second gnt with host_rdata=0xA5.
- disp_req and host_req rise in the same cycle -> display served first; host_gnt one cycle later; wait counter peaked at 1.
- disp_req continuously high for 40 cycles with host_req high:
  - Macro undefined: no host_gnt; host_starve=1 after 16 waits; 40 disp_rvalid pulses.
  - Macro defined: host_gnt at wait 16; exactly one disp_miss; 39 disp_rvalid pulses.
- reset asserted in the cycle after a host read gnt -> host_rvalid never pulses; all outputs 0 immediately (asynchronous).
- Display pulses every other cycle interleaved with a host read stream -> all returns in order with correct tags; no host_gnt in consecutive cycles.
